// File: rtl/rename_stage_if.sv
// Decode, dispatch, commit and flush signals of rename_stage bundled as one port.
// Source-lookup signals exist only when RENAME_SRC_LOOKUP_EN is defined.
interface rename_stage_if #(
  parameter int DSTS      = 2,
  parameter int PR_ADDR_W = 5
);
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [4*DSTS-1:0]         in_dst_arch;
  logic [DSTS-1:0]           in_dst_mask;
  logic                      out_valid;
  logic                      out_ready;
  logic [4*DSTS-1:0]         out_dst_arch;
  logic [PR_ADDR_W*DSTS-1:0] out_dst_phys;
  logic [DSTS-1:0]           out_dst_mask;
  logic                      commit_valid;
  logic [4*DSTS-1:0]         commit_arch;
  logic [PR_ADDR_W*DSTS-1:0] commit_phys;
  logic [DSTS-1:0]           commit_mask;
`ifdef RENAME_SRC_LOOKUP_EN
  logic [7:0]                in_src_arch;
  logic [2*PR_ADDR_W-1:0]    out_src_phys;
`endif

  modport master (
`ifdef RENAME_SRC_LOOKUP_EN
    output in_src_arch,
    input  out_src_phys,
`endif
    output flush, in_valid, in_dst_arch, in_dst_mask, out_ready,
    output commit_valid, commit_arch, commit_phys, commit_mask,
    input  in_ready, out_valid, out_dst_arch, out_dst_phys, out_dst_mask
  );

  modport slave (
`ifdef RENAME_SRC_LOOKUP_EN
    input  in_src_arch,
    output out_src_phys,
`endif
    input  flush, in_valid, in_dst_arch, in_dst_mask, out_ready,
    input  commit_valid, commit_arch, commit_phys, commit_mask,
    output in_ready, out_valid, out_dst_arch, out_dst_phys, out_dst_mask
  );
endinterface

// File: rtl/rename_stage.sv
// In-order register renamer: speculative + committed RAT and free pool held in flops,
// one registered output stage. Optional source lookup under RENAME_SRC_LOOKUP_EN.
module rename_stage #(
  parameter int ARCH_REGS = 10,
  parameter int HARD_REGS = 2,
  parameter int PHYS_REGS = 32,
  parameter int PR_ADDR_W = 5,
  parameter int DSTS      = 2
) (
  input logic           clk,
  input logic           rst,
  rename_stage_if.slave bus
);
  typedef logic [PR_ADDR_W-1:0]                 preg_t;
  typedef logic [3:0]                           areg_t;
  typedef logic [ARCH_REGS-1:0][PR_ADDR_W-1:0]  rat_t;

  localparam areg_t HARD_A = areg_t'(HARD_REGS);
  localparam areg_t ARCH_A = areg_t'(ARCH_REGS);

  function automatic rat_t ident_rat();
    rat_t r;
    for (int a = 0; a < ARCH_REGS; a++) r[a] = preg_t'(a);
    return r;
  endfunction

  localparam rat_t                 RAT_RST   = ident_rat();
  localparam logic [PHYS_REGS-1:0] FREE_RST  = {{(PHYS_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
  localparam logic [PHYS_REGS-1:0] FREE_SOFT = {{(PHYS_REGS-HARD_REGS){1'b1}}, {HARD_REGS{1'b0}}};

  rat_t                      spec_rat_q, spec_rat_d;
  rat_t                      comm_rat_q, comm_rat_d;
  logic [PHYS_REGS-1:0]      free_q, free_d;
  logic                      out_valid_q, out_valid_d;
  logic [4*DSTS-1:0]         out_arch_q, out_arch_d;
  logic [PR_ADDR_W*DSTS-1:0] out_phys_q, out_phys_d;
  logic [DSTS-1:0]           out_mask_q, out_mask_d;

  areg_t                     lane_arch [DSTS];
  preg_t                     lane_phys [DSTS];
  logic  [DSTS-1:0]          lane_ren;
  logic  [PHYS_REGS-1:0]     avail;
  logic                      found;
  logic                      alloc_ok;
  logic                      accept;
  areg_t                     c_arch;
  preg_t                     c_phys;

  // Lanes pick the lowest free regs in lane order; alloc_ok only if every renaming lane found one.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    avail    = free_q;
    found    = 1'b0;
    alloc_ok = 1'b1;
    lane_ren = '0;
    for (int k = 0; k < DSTS; k++) begin
      lane_arch[k] = bus.in_dst_arch[4*k +: 4];
      lane_phys[k] = '0;
      lane_ren[k]  = bus.in_dst_mask[k] && (lane_arch[k] >= HARD_A);
      if (bus.in_dst_mask[k] && !lane_ren[k]) lane_phys[k] = preg_t'(lane_arch[k]);
      if (lane_ren[k]) begin
        found = 1'b0;
        for (int p = 0; p < PHYS_REGS; p++) begin
          if (!found && avail[p]) begin
            found        = 1'b1;
            lane_phys[k] = preg_t'(p);
            avail[p]     = 1'b0;
          end
        end
        if (!found) alloc_ok = 1'b0;
      end
    end
  end

  assign bus.in_ready = (~out_valid_q | bus.out_ready) & ~bus.flush & alloc_ok;
  assign accept       = bus.in_valid & bus.in_ready;

`ifdef RENAME_SRC_LOOKUP_EN
  logic [2*PR_ADDR_W-1:0] src_phys_q, src_phys_d, src_lookup;
  areg_t                  src_a;

  // Sources read the RAT as it stood before this micro-op's own destination writes.
  always_comb begin
    src_lookup = '0;
    src_a      = '0;
    for (int s = 0; s < 2; s++) begin
      src_a = bus.in_src_arch[4*s +: 4];
      if (src_a < HARD_A)      src_lookup[PR_ADDR_W*s +: PR_ADDR_W] = preg_t'(src_a);
      else if (src_a < ARCH_A) src_lookup[PR_ADDR_W*s +: PR_ADDR_W] = spec_rat_q[src_a];
    end
  end

  assign bus.out_src_phys = src_phys_q;
`endif

  always_comb begin
    spec_rat_d  = spec_rat_q;
    comm_rat_d  = comm_rat_q;
    free_d      = free_q;
    out_valid_d = out_valid_q;
    out_arch_d  = out_arch_q;
    out_phys_d  = out_phys_q;
    out_mask_d  = out_mask_q;
    c_arch      = '0;
    c_phys      = '0;
`ifdef RENAME_SRC_LOOKUP_EN
    src_phys_d  = src_phys_q;
`endif

    if (bus.commit_valid) begin
      for (int k = 0; k < DSTS; k++) begin
        c_arch = bus.commit_arch[4*k +: 4];
        c_phys = bus.commit_phys[PR_ADDR_W*k +: PR_ADDR_W];
        if (bus.commit_mask[k] && c_arch >= HARD_A && c_arch < ARCH_A) begin
          free_d[comm_rat_d[c_arch]] = 1'b1;
          comm_rat_d[c_arch]         = c_phys;
        end
      end
    end

    if (bus.flush) begin
      // Rebuild from the committed view, including this cycle's commit.
      spec_rat_d = comm_rat_d;
      free_d     = FREE_SOFT;
      for (int a = 0; a < ARCH_REGS; a++) free_d[comm_rat_d[a]] = 1'b0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      for (int k = 0; k < DSTS; k++) begin
        out_phys_d[PR_ADDR_W*k +: PR_ADDR_W] = lane_phys[k];
        if (lane_ren[k]) begin
          free_d[lane_phys[k]] = 1'b0;
          if (lane_arch[k] < ARCH_A) spec_rat_d[lane_arch[k]] = lane_phys[k];
        end
      end
      out_valid_d = 1'b1;
      out_arch_d  = bus.in_dst_arch;
      out_mask_d  = bus.in_dst_mask;
`ifdef RENAME_SRC_LOOKUP_EN
      src_phys_d  = src_lookup;
`endif
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the RATs and free pool are flops rather than RAM, so they take a reset value.
      spec_rat_q  <= RAT_RST;
      comm_rat_q  <= RAT_RST;
      free_q      <= FREE_RST;
      out_valid_q <= 1'b0;
      out_arch_q  <= '0;
      out_phys_q  <= '0;
      out_mask_q  <= '0;
`ifdef RENAME_SRC_LOOKUP_EN
      src_phys_q  <= '0;
`endif
    end else begin
      // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
      spec_rat_q  <= spec_rat_d;
      comm_rat_q  <= comm_rat_d;
      free_q      <= free_d;
      out_valid_q <= out_valid_d;
      out_arch_q  <= out_arch_d;
      out_phys_q  <= out_phys_d;
      out_mask_q  <= out_mask_d;
`ifdef RENAME_SRC_LOOKUP_EN
      src_phys_q  <= src_phys_d;
`endif
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_dst_arch = out_arch_q;
  assign bus.out_dst_phys = out_phys_q;
  assign bus.out_dst_mask = out_mask_q;
endmodule

// File: tb/tb_rename_stage.sv
// Directed self-checking bench for rename_stage: reset, allocation order, pool drain,
// hard regs, back-pressure and flush recovery.
module tb_rename_stage;
  localparam int PW = 5;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rename_stage_if #(.DSTS(2), .PR_ADDR_W(PW)) bus ();

  rename_stage #(
    .ARCH_REGS(10), .HARD_REGS(2), .PHYS_REGS(32), .PR_ADDR_W(PW), .DSTS(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic idle_inputs;
    bus.flush        = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_dst_arch  = '0;
    bus.in_dst_mask  = '0;
    bus.out_ready    = 1'b1;
    bus.commit_valid = 1'b0;
    bus.commit_arch  = '0;
    bus.commit_phys  = '0;
    bus.commit_mask  = '0;
`ifdef RENAME_SRC_LOOKUP_EN
    bus.in_src_arch  = '0;
`endif
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Present a micro-op at the falling edge and let it settle.
  task automatic send(input logic [3:0] a1, input logic [3:0] a0, input logic [1:0] m);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_dst_arch = {a1, a0};
    bus.in_dst_mask = m;
    #1;
  endtask

  task automatic latch;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0h want 0", bus.out_valid); end
    checks++; if (bus.out_dst_phys !== 10'd0) begin errors++; $display("FAIL reset_out_phys: got %0h want 0", bus.out_dst_phys); end
    checks++; if (bus.out_dst_arch !== 8'd0) begin errors++; $display("FAIL reset_out_arch: got %0h want 0", bus.out_dst_arch); end
    checks++; if (bus.out_dst_mask !== 2'd0) begin errors++; $display("FAIL reset_out_mask: got %0h want 0", bus.out_dst_mask); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0h want 1", bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_rename;
    apply_reset();
    send(4'd5, 4'd3, 2'b11);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %0h want 1", bus.in_ready); end
    latch();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0h want 1", bus.out_valid); end
    checks++; if (bus.out_dst_phys !== {5'd11, 5'd10}) begin errors++; $display("FAIL basic_phys: got %0h want %0h", bus.out_dst_phys, {5'd11, 5'd10}); end
    checks++; if (bus.out_dst_arch !== 8'h53) begin errors++; $display("FAIL basic_arch: got %0h want 53", bus.out_dst_arch); end
    checks++; if (bus.out_dst_mask !== 2'b11) begin errors++; $display("FAIL basic_mask: got %0h want 3", bus.out_dst_mask); end

`ifdef RENAME_SRC_LOOKUP_EN
    bus.in_src_arch = {4'd5, 4'd3};
`endif
    send(4'd4, 4'd4, 2'b11);
    latch();
    checks++; if (bus.out_dst_phys !== {5'd13, 5'd12}) begin errors++; $display("FAIL same_arch_phys: got %0h want %0h", bus.out_dst_phys, {5'd13, 5'd12}); end
`ifdef RENAME_SRC_LOOKUP_EN
    checks++; if (bus.out_src_phys !== {5'd11, 5'd10}) begin errors++; $display("FAIL src_after_first: got %0h want %0h", bus.out_src_phys, {5'd11, 5'd10}); end
    bus.in_src_arch = {4'd4, 4'd1};
`endif

    send(4'd7, 4'd1, 2'b11);
    latch();
    checks++; if (bus.out_dst_phys !== {5'd14, 5'd1}) begin errors++; $display("FAIL hard_lane_phys: got %0h want %0h", bus.out_dst_phys, {5'd14, 5'd1}); end
`ifdef RENAME_SRC_LOOKUP_EN
    checks++; if (bus.out_src_phys !== {5'd13, 5'd1}) begin errors++; $display("FAIL src_high_lane_wins: got %0h want %0h", bus.out_src_phys, {5'd13, 5'd1}); end
    bus.in_src_arch = '0;
`endif

    send(4'd9, 4'd8, 2'b10);
    latch();
    checks++; if (bus.out_dst_phys !== {5'd15, 5'd0}) begin errors++; $display("FAIL masked_lane_phys: got %0h want %0h", bus.out_dst_phys, {5'd15, 5'd0}); end
    checks++; if (bus.out_dst_arch !== 8'h98) begin errors++; $display("FAIL masked_lane_arch: got %0h want 98", bus.out_dst_arch); end

    send(4'd0, 4'd6, 2'b01);
    latch();
    checks++; if (bus.out_dst_phys !== {5'd0, 5'd16}) begin errors++; $display("FAIL pool_advance: got %0h want %0h", bus.out_dst_phys, {5'd0, 5'd16}); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_drain_and_hard;
    logic [9:0] exp;
    apply_reset();
    for (int i = 0; i < 21; i++) begin
      send(4'd0, 4'd2, 2'b01);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL drain_ready[%0d]: got %0h want 1", i, bus.in_ready); end
      latch();
      exp = {5'd0, 5'(10 + i)};
      checks++; if (bus.out_dst_phys !== exp) begin errors++; $display("FAIL drain_phys[%0d]: got %0h want %0h", i, bus.out_dst_phys, exp); end
    end

    send(4'd3, 4'd2, 2'b11);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL two_lanes_one_free: got %0h want 0", bus.in_ready); end
    latch();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL no_partial_accept: got %0h want 0", bus.out_valid); end

    send(4'd0, 4'd2, 2'b01);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL last_free_ready: got %0h want 1", bus.in_ready); end
    latch();
    checks++; if (bus.out_dst_phys !== {5'd0, 5'd31}) begin errors++; $display("FAIL last_free_phys: got %0h want %0h", bus.out_dst_phys, {5'd0, 5'd31}); end

    send(4'd0, 4'd2, 2'b01);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL empty_pool_ready: got %0h want 0", bus.in_ready); end

    send(4'd1, 4'd0, 2'b11);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL hard_empty_ready: got %0h want 1", bus.in_ready); end
    latch();
    checks++; if (bus.out_dst_phys !== {5'd1, 5'd0}) begin errors++; $display("FAIL hard_empty_phys: got %0h want %0h", bus.out_dst_phys, {5'd1, 5'd0}); end

    send(4'd7, 4'd6, 2'b00);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL nodest_ready: got %0h want 1", bus.in_ready); end
    latch();
    checks++; if (bus.out_dst_phys !== 10'd0) begin errors++; $display("FAIL nodest_phys: got %0h want 0", bus.out_dst_phys); end

    send(4'd0, 4'd2, 2'b01);
    bus.commit_valid = 1'b1;
    bus.commit_arch  = {4'd0, 4'd2};
    bus.commit_phys  = {5'd0, 5'd10};
    bus.commit_mask  = 2'b01;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL commit_same_cycle: got %0h want 0", bus.in_ready); end
    latch();
    bus.commit_valid = 1'b0;
    bus.commit_mask  = 2'b00;
    @(negedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL commit_next_cycle: got %0h want 1", bus.in_ready); end
    latch();
    checks++; if (bus.out_dst_phys !== {5'd0, 5'd2}) begin errors++; $display("FAIL freed_phys: got %0h want %0h", bus.out_dst_phys, {5'd0, 5'd2}); end
    send(4'd0, 4'd2, 2'b01);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL empty_again: got %0h want 0", bus.in_ready); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_back_pressure;
    apply_reset();
    send(4'd0, 4'd7, 2'b01);
    latch();
    checks++; if (bus.out_dst_phys !== {5'd0, 5'd10}) begin errors++; $display("FAIL bp_first_phys: got %0h want %0h", bus.out_dst_phys, {5'd0, 5'd10}); end
    @(negedge clk);
    bus.out_ready   = 1'b0;
    bus.in_dst_arch = {4'd0, 4'd6};
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %0h want 0", c, bus.in_ready); end
      latch();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %0h want 1", c, bus.out_valid); end
      checks++; if (bus.out_dst_phys !== {5'd0, 5'd10}) begin errors++; $display("FAIL bp_phys[%0d]: got %0h want %0h", c, bus.out_dst_phys, {5'd0, 5'd10}); end
      checks++; if (bus.out_dst_arch !== 8'h07) begin errors++; $display("FAIL bp_arch[%0d]: got %0h want 07", c, bus.out_dst_arch); end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0h want 1", bus.in_ready); end
    latch();
    checks++; if (bus.out_dst_phys !== {5'd0, 5'd11}) begin errors++; $display("FAIL bp_no_alloc: got %0h want %0h", bus.out_dst_phys, {5'd0, 5'd11}); end
    checks++; if (bus.out_dst_arch !== 8'h06) begin errors++; $display("FAIL bp_release_arch: got %0h want 06", bus.out_dst_arch); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_flush;
    logic [9:0] exp;
    int         accepted;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      send(4'd0, 4'(2 + i), 2'b01);
      latch();
      exp = {5'd0, 5'(10 + i)};
      checks++; if (bus.out_dst_phys !== exp) begin errors++; $display("FAIL b2b_phys[%0d]: got %0h want %0h", i, bus.out_dst_phys, exp); end
    end
    bus.in_valid = 1'b0;

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.out_ready    = 1'b0;
      bus.commit_valid = 1'b1;
      bus.commit_arch  = {4'd0, 4'(2 + c)};
      bus.commit_phys  = {5'd0, 5'(10 + c)};
      bus.commit_mask  = 2'b01;
      if (c == 2) begin
        bus.flush       = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_dst_arch = {4'd0, 4'd9};
        bus.in_dst_mask = 2'b01;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %0h want 0", bus.in_ready); end
      end
      latch();
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %0h want 0", bus.out_valid); end
    idle_inputs();

`ifdef RENAME_SRC_LOOKUP_EN
    bus.in_src_arch = {4'd5, 4'd2};
    send(4'd0, 4'd0, 2'b00);
    latch();
    checks++; if (bus.out_src_phys !== {5'd5, 5'd10}) begin errors++; $display("FAIL flush_spec_rat: got %0h want %0h", bus.out_src_phys, {5'd5, 5'd10}); end
    bus.in_src_arch = '0;
`endif

    accepted = 0;
    for (int i = 0; i < 22; i++) begin
      send(4'd0, 4'd8, 2'b01);
      if (bus.in_ready === 1'b1) accepted++;
      latch();
      exp = (i < 3) ? {5'd0, 5'(2 + i)} : {5'd0, 5'(10 + i)};
      checks++; if (bus.out_dst_phys !== exp) begin errors++; $display("FAIL flush_pool_phys[%0d]: got %0h want %0h", i, bus.out_dst_phys, exp); end
    end
    send(4'd0, 4'd8, 2'b01);
    if (bus.in_ready === 1'b1) accepted++;
    checks++; if (accepted !== 22) begin errors++; $display("FAIL flush_pool_count: got %0d want 22", accepted); end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_rename();
    test_drain_and_hard();
    test_back_pressure();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
